// File: rtl/usb_init_pkg.sv
// Shared state encodings, parameter defaults and sizing helper for the USB
// clock-init reset sequencer.
package usb_init_pkg;

    typedef enum logic [2:0] {
        ST_CLKRST   = 3'd0,
        ST_WAITLOCK = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_READY    = 3'd3,
        ST_FAIL     = 3'd4
    } state_e;

    localparam int NUM_CLK_DEF       = 2;
    localparam int RST_CYCLES_DEF    = 65536;
    localparam int SETTLE_CYCLES_DEF = 33554432;
    localparam int LOCK_TIMEOUT_DEF  = 1048576;
    localparam int MAX_RETRY_DEF     = 3;

    // Counter width covering the longest of the three timed phases.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bundle of independent asynchronous bits.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/usb_reset_seq.sv
// Clock-generator reset sequencer: pulses clk_rst, waits for all unmasked PLL
// locks, requires a settle window, retries on timeout and reports ready/fail.
module usb_reset_seq
    import usb_init_pkg::*;
#(
    parameter int NUM_CLK       = NUM_CLK_DEF,
    parameter int RST_CYCLES    = RST_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
    parameter int MAX_RETRY     = MAX_RETRY_DEF
) (
    input  logic                           clk,
    input  logic                           rst_in,
    input  logic [NUM_CLK-1:0]             lock,
    input  logic [NUM_CLK-1:0]             lock_mask,
    input  logic                           wakeup,
    output logic                           clk_rst,
    output logic                           n_ready,
    output logic [2:0]                     state,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
    output logic                           fail,
    output logic                           lock_lost
);

    localparam int CW = cnt_width(RST_CYCLES, SETTLE_CYCLES, LOCK_TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);

    logic [NUM_CLK-1:0] lock_sync;
    logic               all_lock;
    logic               wake_q, wake_edge;
    logic               timeout;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          clk_rst_d, n_ready_d, fail_d, lost_d;

    sync_2ff #(.WIDTH(NUM_CLK)) u_lock_sync (
        .clk    (clk),
        .rst_in (rst_in),
        .d      (lock),
        .q      (lock_sync)
    );

    assign all_lock  = &(lock_sync | lock_mask);
    assign wake_edge = wakeup & ~wake_q;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_CLKRST;
            cnt_q     <= '0;
            retry_q   <= '0;
            wake_q    <= 1'b0;
            clk_rst   <= 1'b1;
            n_ready   <= 1'b1;
            fail      <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            wake_q    <= wakeup;
            clk_rst   <= clk_rst_d;
            n_ready   <= n_ready_d;
            fail      <= fail_d;
            lock_lost <= lost_d;
        end
    end

    // A wakeup edge overrides whatever the lock inputs say this cycle.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        if (wake_edge) begin
            state_d = ST_CLKRST;
        end else begin
            case (state_q)
                ST_CLKRST:   if (cnt_q == RST_LAST) state_d = ST_WAITLOCK;
                ST_WAITLOCK: begin
                    if (all_lock) begin
                        state_d = ST_SETTLE;
                    end else if (cnt_q == TMO_LAST) begin
                        timeout = 1'b1;
                        state_d = (int'(retry_q) + 1 < MAX_RETRY) ? ST_CLKRST : ST_FAIL;
                    end
                end
                ST_SETTLE: begin
                    if (!all_lock)                  state_d = ST_CLKRST;
                    else if (cnt_q == SETTLE_LAST)  state_d = ST_READY;
                end
                ST_READY:    if (!all_lock) state_d = ST_CLKRST;
                ST_FAIL:     state_d = ST_FAIL;
                default:     state_d = ST_CLKRST;
            endcase
        end
    end

    // Counter only runs in the timed phases and is cleared on any transition,
    // so it never exceeds its phase limit and cannot wrap.
    always_comb begin
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        fail_d    = fail | (state_d == ST_FAIL);
        lost_d    = lock_lost | (state_q == ST_READY && !all_lock);
        clk_rst_d = (state_d == ST_CLKRST);
        n_ready_d = !(state_q == ST_READY && state_d == ST_READY);
        if (state_d != state_q || wake_edge)
            cnt_d = '0;
        else if (state_q == ST_CLKRST || state_q == ST_WAITLOCK || state_q == ST_SETTLE)
            cnt_d = cnt_q + 1'b1;
        if (wake_edge) begin
            retry_d = '0;
            fail_d  = 1'b0;
            lost_d  = 1'b0;
        end else if (timeout) begin
            retry_d = retry_q + 1'b1;
        end else if (state_q == ST_READY && !all_lock) begin
            retry_d = '0;
        end
    end

    assign state     = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_usb_reset_seq.sv
// Directed bench for usb_reset_seq with short timing parameters.
module tb_usb_reset_seq;

    logic       clk = 1'b0;
    logic       rst_in;
    logic [1:0] lock, lock_mask;
    logic       wakeup;
    logic       clk_rst, n_ready, fail, lock_lost;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    int total = 0;
    int bad   = 0;
    int hi, r1, r2, r3, h2, h3;

    usb_reset_seq #(
        .NUM_CLK(2), .RST_CYCLES(8), .SETTLE_CYCLES(16),
        .LOCK_TIMEOUT(32), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst_in(rst_in), .lock(lock), .lock_mask(lock_mask),
        .wakeup(wakeup), .clk_rst(clk_rst), .n_ready(n_ready), .state(state),
        .retry_cnt(retry_cnt), .fail(fail), .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Samples clk_rst at the current negedge and n-1 further ones, ending one
    // negedge past the last sample; counts high samples and 0->1 rises.
    task automatic sample_rst(input int n, input logic prev_in, output int h, output int rises);
        logic prev;
        prev  = prev_in;
        h     = 0;
        rises = 0;
        for (int i = 0; i < n; i++) begin
            if (clk_rst) h++;
            if (clk_rst && !prev) rises++;
            prev = clk_rst;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_in = 1'b1; lock = 2'b11; lock_mask = 2'b00; wakeup = 1'b0;
        step(2);
        chk("rst_state",   state, 0);
        chk("rst_clk_rst", clk_rst, 1);
        chk("rst_n_ready", n_ready, 1);
        chk("rst_retry",   retry_cnt, 0);
        chk("rst_fail",    fail, 0);
        chk("rst_lost",    lock_lost, 0);

        // Clean bring-up: 8 reset cycles, 1 to see lock, 16 settle, 1 registered.
        rst_in = 1'b0;
        sample_rst(12, 1'b0, hi, r1);
        chk("up_rst_width", hi, 8);
        chk("up_settle_state", state, 2);
        step(13);
        chk("up_e25_n_ready", n_ready, 1);
        chk("up_e25_state", state, 3);
        step(1);
        chk("up_e26_n_ready", n_ready, 0);

        // One-cycle glitch on lock[1] while READY.
        lock = 2'b01; step(1);
        lock = 2'b11; step(2);
        chk("lost_state",   state, 0);
        chk("lost_flag",    lock_lost, 1);
        chk("lost_n_ready", n_ready, 1);
        chk("lost_retry",   retry_cnt, 0);
        sample_rst(12, 1'b0, hi, r1);
        chk("lost_rst_width", hi, 8);

        // No lock at all: two timeouts, then FAIL.
        rst_in = 1'b1; lock = 2'b00; step(1);
        rst_in = 1'b0;
        sample_rst(39, 1'b0, hi, r1);
        chk("tmo_e39_state", state, 1);
        chk("tmo_e39_retry", retry_cnt, 0);
        sample_rst(1, 1'b0, h2, r2);
        chk("tmo_e40_state", state, 0);
        chk("tmo_e40_retry", retry_cnt, 1);
        sample_rst(60, 1'b0, h3, r3);
        chk("tmo_pulses",  r1 + r2 + r3, 2);
        chk("tmo_hi",      hi + h2 + h3, 16);
        chk("tmo_state",   state, 4);
        chk("tmo_fail",    fail, 1);
        chk("tmo_retry",   retry_cnt, 2);
        chk("tmo_clk_rst", clk_rst, 0);
        chk("tmo_n_ready", n_ready, 1);

        // Wakeup out of FAIL, held high: a single restart reaching READY.
        lock = 2'b11; wakeup = 1'b1; step(1);
        chk("wake_state", state, 0);
        chk("wake_fail",  fail, 0);
        chk("wake_retry", retry_cnt, 0);
        chk("wake_clk_rst", clk_rst, 1);
        sample_rst(99, 1'b0, hi, r1);
        chk("wake_hold_rises", r1, 1);
        chk("wake_hold_state", state, 3);
        chk("wake_hold_n_ready", n_ready, 0);
        wakeup = 1'b0; step(3);
        chk("wake_fall_state", state, 3);
        wakeup = 1'b1; step(1);
        chk("wake2_state", state, 0);
        chk("wake2_clk_rst", clk_rst, 1);
        wakeup = 1'b0;

        // Masked channel: lock[1] toggles freely without effect.
        rst_in = 1'b1; lock_mask = 2'b10; lock = 2'b01; step(1);
        rst_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            lock[1] = ~lock[1];
            step(1);
        end
        chk("mask_state",   state, 3);
        chk("mask_n_ready", n_ready, 0);
        for (int i = 0; i < 10; i++) begin
            lock[1] = ~lock[1];
            step(1);
        end
        chk("mask_hold_state", state, 3);
        chk("mask_lost", lock_lost, 0);

        // Asynchronous reset in the middle of SETTLE.
        rst_in = 1'b1; lock_mask = 2'b00; lock = 2'b11; step(1);
        rst_in = 1'b0; step(15);
        chk("mid_pre_state",   state, 2);
        chk("mid_pre_clk_rst", clk_rst, 0);
        rst_in = 1'b1; #1;
        chk("mid_async_state",   state, 0);
        chk("mid_async_clk_rst", clk_rst, 1);
        chk("mid_async_n_ready", n_ready, 1);
        step(1);
        rst_in = 1'b0;
        sample_rst(12, 1'b0, hi, r1);
        chk("mid_restart_width", hi, 8);
        chk("mid_restart_state", state, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_reset_seq.md
USB_RESET_SEQ -- requirements
Module: usb_reset_seq

Interface
REQ-001 SHALL have parameter NUM_CLK, default 2, number of clock-lock channels monitored.
REQ-002 SHALL have parameter RST_CYCLES, default 65536, clock-reset pulse width in clk cycles (min 2).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 33554432, lock-stable cycles required before ready (min 2).
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 1048576, max cycles waiting for lock per attempt (min 2).
REQ-005 SHALL have parameter MAX_RETRY, default 3, reset attempts allowed before FAIL (min 1).
REQ-006 SHALL have port clk  input  1  system clock, free-running, independent of monitored clocks.
REQ-007 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port lock  input  NUM_CLK  per-channel PLL/DCM lock, asynchronous to clk.
REQ-009 SHALL have port lock_mask  input  NUM_CLK  1 = channel ignored (treated as locked); quasi-static.
REQ-010 SHALL have port wakeup  input  1  synchronous restart request; rising edge acts.
REQ-011 SHALL have port clk_rst  output  1  reset to clock generators, active-high, registered.
REQ-012 SHALL have port n_ready  output  1  0 = all unmasked clocks locked and settled, registered.
REQ-013 SHALL have port state  output  3  current FSM state encoding.
REQ-014 SHALL have port retry_cnt  output  $clog2(MAX_RETRY+1)  attempts that timed out in current sequence.
REQ-015 SHALL have port fail  output  1  retries exhausted, sticky.
REQ-016 SHALL have port lock_lost  output  1  sticky: lock dropped while in READY.

Function
REQ-017 Each lock bit SHALL pass a 2-FF synchronizer; all_lock = AND over (lock_sync | lock_mask).
REQ-018 FSM states/encodings SHALL be CLKRST=0, WAITLOCK=1, SETTLE=2, READY=3, FAIL=4.
REQ-019 CLKRST: clk_rst=1 for exactly RST_CYCLES cycles, then -> WAITLOCK, counter cleared.
REQ-020 WAITLOCK: all_lock=1 -> SETTLE; counter reaching LOCK_TIMEOUT-1 without lock -> retry_cnt+1, then CLKRST if retry_cnt+1 < MAX_RETRY, else FAIL.
REQ-021 SETTLE: all_lock held for SETTLE_CYCLES consecutive cycles -> READY; any all_lock=0 -> CLKRST (retry_cnt unchanged).
REQ-022 READY: n_ready=0; all_lock=0 -> CLKRST, lock_lost=1, retry_cnt cleared.
REQ-023 FAIL: clk_rst=0, n_ready=1, fail=1; held until rst_in or wakeup edge.
REQ-024 n_ready SHALL be 1 in every state except READY; deasserts one cycle after entering READY (registered).
REQ-025 wakeup rising edge (registered edge detect) in any state SHALL force CLKRST, clear counter, retry_cnt, fail, lock_lost; takes priority over same-cycle lock events.
REQ-026 wakeup held high SHALL NOT retrigger; only 0->1 transitions act.
REQ-027 Single shared counter sized $clog2 of max(RST_CYCLES, SETTLE_CYCLES, LOCK_TIMEOUT); cleared on every state change; no wrap in any state.
REQ-028 Illegal state encodings SHALL recover to CLKRST next cycle.

Reset
REQ-029 rst_in=1 SHALL asynchronously force state=CLKRST, counter=0, clk_rst=1, n_ready=1, retry_cnt=0, fail=0, lock_lost=0, synchronizer and wakeup-edge flops=0.
REQ-030 After rst_in release the RST_CYCLES count SHALL start on the first clk edge; reset mid-sequence restarts from CLKRST.

Structure
REQ-031 State encodings and parameter defaults SHALL live in shared package usb_init_pkg.
REQ-032 Lock synchronizer SHALL be sub-module sync_2ff (parametrised width), instantiated once with width NUM_CLK.

Verification (RST_CYCLES=8, SETTLE_CYCLES=16, LOCK_TIMEOUT=32, MAX_RETRY=2, NUM_CLK=2)
REQ-033 Release rst_in, lock=2'b11 -> clk_rst high 8 cycles, n_ready falls 8+1+16+1 cycles (plus 2 sync) later, state=3.
REQ-034 lock=2'b00 throughout -> two timeouts, retry_cnt=2, state=4, fail=1, clk_rst pulsed exactly twice.
REQ-035 In READY drop lock[1] for 1 cycle -> lock_lost=1, state=0, n_ready=1, new 8-cycle clk_rst pulse.
REQ-036 lock_mask=2'b10, lock=2'b01 -> reaches READY; lock[1] toggling has no effect.
REQ-037 In FAIL, pulse wakeup -> fail=0, retry_cnt=0, state=0 next cycle; wakeup held high 100 cycles -> only one restart.
REQ-038 Assert rst_in mid-SETTLE -> all outputs at reset values immediately, sequence restarts on release.
